shift_sequencer: RTL and testbench

//  Iterative shift controller for the ARM operand-2 path: accepts one shift command
//  (data, amount, op) and produces the result by applying one 1-bit shift per clock.

---
 rtl/shift_sequencer.sv | 137 +++++++++++++
 tb/tb_shift_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Iterative operand-2 shifter. One command (data, amount, op, carry-in) is
//   accepted, then one 1-bit shift is applied per clock until the amount is
//   exhausted. The result is held on out_data/out_carry until the consumer
//   takes it.
//
// Parameters
//   WIDTH  datapath width in bits
//   AMT_W  shift-amount width; amounts 0..2**AMT_W-1 accepted
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   command present
//   in_ready   command accepted on an edge where in_valid & in_ready
//   in_data    operand to shift
//   in_amt     shift amount
//   in_op      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_carry   current C flag, passed through when the amount is 0
//   out_valid  result present, held until taken
//   out_ready  consumer takes the result on an edge where out_valid & out_ready
//   out_data   shifted result
//   out_carry  last bit shifted out
//   busy       high while shifting
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'd0,
    OP_LSR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROR = 2'd3
  } op_t;

  state_t           state;
  state_t           state_nxt;
  op_t              op_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             accept;
  logic [WIDTH:0]   step;

  // One 1-bit shift; result packed as {carry_out, data}.
  function automatic logic [WIDTH:0] shift_step(input op_t op, input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] ds;
    ds = $signed(d);
    case (op)
      OP_LSL:  shift_step = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      OP_LSR:  shift_step = {d[0], 1'b0, d[WIDTH-1:1]};
      OP_ASR:  shift_step = {d[0], ds >>> 1};
      OP_ROR:  shift_step = {d[0], d[0], d[WIDTH-1:1]};
      default: shift_step = {1'b0, d};
    endcase
  endfunction

  // in_ready is the only Mealy output: in DONE a taken result frees the slot
  // on the same edge, so a new command can follow with no idle cycle.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign step      = shift_step(op_q, data_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (in_amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == AMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = (in_amt == '0) ? DONE : SHIFT;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture at accept, then one iteration per SHIFT cycle.
  // Amounts >= WIDTH simply keep iterating, which yields the saturating
  // LSL/LSR/ASR results and the natural ROR wrap without special cases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      op_q    <= OP_LSL;
    end else if (accept) begin
      data_q  <= in_data;
      carry_q <= in_carry;
      count   <= in_amt;
      op_q    <= op_t'(in_op);
    end else if (state == SHIFT) begin
      data_q  <= step[WIDTH-1:0];
      carry_q <= step[WIDTH];
      count   <= count - AMT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Whole-shift result from closed-form arithmetic, packed {carry, data}.
  function automatic logic [16:0] model_shift(input logic [15:0] d, input int n,
                                              input logic [1:0] op, input logic cin);
    logic [31:0]        w;
    logic signed [31:0] s;
    logic [15:0]        res;
    if (n == 0) return {cin, d};
    case (op)
      2'b00: begin w = {16'b0, d} << n; return {w[16], w[15:0]}; end
      2'b01: begin w = {d, 16'b0} >> n; return {w[15], w[31:16]}; end
      2'b10: begin s = $signed({d, 16'b0}) >>> n; return {s[15], s[31:16]}; end
      default: begin
        w = {d, d} >> (n % 16);
        res = w[15:0];
        return {res[15], res};
      end
    endcase
  endfunction

  // Transaction-level model: a pending result, and cycles left before it shows.
  logic        m_valid = 1'b0;
  int          m_rem   = 0;
  logic [15:0] m_data  = '0;
  logic        m_carry = 1'b0;

  function automatic logic m_in_ready();
    return (!m_valid && m_rem == 0) || (m_valid && out_ready);
  endfunction

  always @(posedge clock or posedge reset) begin
    logic        acc;
    logic [16:0] r;
    if (reset) begin
      m_valid = 1'b0;
      m_rem   = 0;
      m_data  = '0;
      m_carry = 1'b0;
    end else begin
      acc = in_valid && m_in_ready();
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        r = model_shift(in_data, int'(in_amt), in_op, in_carry);
        m_data  = r[15:0];
        m_carry = r[16];
        if (in_amt == 5'd0) m_valid = 1'b1;
        else begin
          m_rem   = int'(in_amt);
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_busy", 32'(busy), 32'(m_rem != 0));
      chk("cmp_in_ready", 32'(in_ready), 32'(m_in_ready()));
      if (m_valid) begin
        chk("cmp_out_data", 32'(out_data), 32'(m_data));
        chk("cmp_out_carry", 32'(out_carry), 32'(m_carry));
      end
    end
  end

  // Called just after a clock edge with the DUT idle and out_ready=1.
  task automatic run_cmd(input string name, input logic [15:0] d, input logic [4:0] amt,
                         input logic [1:0] op, input logic cin,
                         input logic [15:0] ed, input logic ec);
    int lat;
    int bcnt;
    in_valid = 1'b1; in_data = d; in_amt = amt; in_op = op; in_carry = cin;
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = 16'hDEAD; in_amt = 5'd7; in_carry = ~cin;
    lat = 0;
    bcnt = 0;
    while (!out_valid && lat < 64) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(amt));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(amt));
    chk({name, "_data"}, 32'(out_data), 32'(ed));
    chk({name, "_carry"}, 32'(out_carry), 32'(ec));
    @(posedge clock); #1;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_carry = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    cmp_en = 1'b1;

    run_cmd("lsl1",     16'h000B, 5'd1,  2'b00, 1'b0, 16'h0016, 1'b0);
    run_cmd("lsr1",     16'h8001, 5'd1,  2'b01, 1'b0, 16'h4000, 1'b1);
    run_cmd("asr3",     16'h8000, 5'd3,  2'b10, 1'b1, 16'hF000, 1'b0);
    run_cmd("ror4",     16'h0001, 5'd4,  2'b11, 1'b0, 16'h1000, 1'b0);
    run_cmd("amt0",     16'h1234, 5'd0,  2'b00, 1'b1, 16'h1234, 1'b1);
    run_cmd("lsl16",    16'hFFFF, 5'd16, 2'b00, 1'b0, 16'h0000, 1'b1);
    run_cmd("lsl17",    16'hFFFF, 5'd17, 2'b00, 1'b1, 16'h0000, 1'b0);
    run_cmd("lsr16",    16'h8000, 5'd16, 2'b01, 1'b0, 16'h0000, 1'b1);
    run_cmd("asr20",    16'h8000, 5'd20, 2'b10, 1'b0, 16'hFFFF, 1'b1);
    run_cmd("ror17",    16'h8001, 5'd17, 2'b11, 1'b0, 16'hC000, 1'b1);
    run_cmd("lsr31",    16'hA5A5, 5'd31, 2'b01, 1'b1, 16'h0000, 1'b0);

    // Backpressure: hold the result, ignore commands, then back-to-back accept.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0003; in_amt = 5'd2; in_op = 2'b00; in_carry = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 5'd0; in_op = 2'b11; in_carry = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h000C);
      chk("bp_hold_carry", 32'(out_carry), 32'd0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_data = 16'h8001; in_amt = 5'd1; in_op = 2'b01; in_carry = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("bp_next_busy", 32'(busy), 32'd1);
    chk("bp_next_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("bp_next_out_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h4000);
    chk("bp_next_carry", 32'(out_carry), 32'd1);
    @(posedge clock); #1;

    // Reset in the middle of a 10-step shift.
    in_valid = 1'b1; in_data = 16'h0001; in_amt = 5'd10; in_op = 2'b00; in_carry = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("mid_busy_before_reset", 32'(busy), 32'd1);
    chk("mid_data_before_reset", 32'(out_data), 32'h0010);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_carry", 32'(out_carry), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    run_cmd("post_rst", 16'h000B, 5'd1, 2'b00, 1'b0, 16'h0016, 1'b0);
    run_cmd("post_rst_ror", 16'h00F0, 5'd4, 2'b11, 1'b1, 16'h000F, 1'b0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
